reflet_vga_pixel_arbiter: RTL and testbench

Write-port controller for the VGA frame buffer block. It shares the single pixel write port (write_en, h_pixel, v_pixel, R/G/B) between a direct single-pixel requester and a built-in rectangle-fill sequencer. The sequencer expands one fill command into a raster-ordered stream of pixel writes. Outputs are registered and connect straight to the frame buffer pixel input.

---
 rtl/reflet_vga_pixel_arbiter.sv | 134 +++++++++++++
 tb/tb_reflet_vga_pixel_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reflet_vga_pixel_arbiter.sv
// reflet_vga_pixel_arbiter: shares the frame buffer pixel write port between direct pixel writes and a rectangle-fill sequencer.
module reflet_vga_pixel_arbiter #(
  parameter int H_SIZE      = 640,
  parameter int V_LINE      = 480,
  parameter int COLOR_DEPTH = 8,
  parameter int HW          = $clog2(H_SIZE),
  parameter int VW          = $clog2(V_LINE)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_px_valid,
  output logic                   o_px_ready,
  input  logic [HW-1:0]          i_px_h,
  input  logic [VW-1:0]          i_px_v,
  input  logic [COLOR_DEPTH-1:0] i_px_R,
  input  logic [COLOR_DEPTH-1:0] i_px_G,
  input  logic [COLOR_DEPTH-1:0] i_px_B,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [HW-1:0]          i_cmd_h0,
  input  logic [VW-1:0]          i_cmd_v0,
  input  logic [HW-1:0]          i_cmd_h1,
  input  logic [VW-1:0]          i_cmd_v1,
  input  logic [COLOR_DEPTH-1:0] i_cmd_R,
  input  logic [COLOR_DEPTH-1:0] i_cmd_G,
  input  logic [COLOR_DEPTH-1:0] i_cmd_B,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_write_en,
  output logic [HW-1:0]          o_h_pixel,
  output logic [VW-1:0]          o_v_pixel,
  output logic [COLOR_DEPTH-1:0] o_R_out,
  output logic [COLOR_DEPTH-1:0] o_G_out,
  output logic [COLOR_DEPTH-1:0] o_B_out
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [HW:0] H_LIM  = (HW+1)'(H_SIZE);
  localparam logic [VW:0] V_LIM  = (VW+1)'(V_LINE);
  localparam logic [HW:0] H_LAST = (HW+1)'(H_SIZE - 1);
  localparam logic [VW:0] V_LAST = (VW+1)'(V_LINE - 1);

  state_t                 r_state;
  logic                   r_last_fill;
  logic [HW-1:0]          r_h, r_h0, r_h1;
  logic [VW-1:0]          r_v, r_v1;
  logic [COLOR_DEPTH-1:0] r_cr, r_cg, r_cb;
  logic                   r_done, r_we;
  logic [HW-1:0]          r_hp;
  logic [VW-1:0]          r_vp;
  logic [COLOR_DEPTH-1:0] r_ro, r_go, r_bo;

  logic          w_grant_px, w_grant_fill, w_cmd_acc, w_degen, w_px_in, w_last;
  logic [HW-1:0] w_h1c;
  logic [VW-1:0] w_v1c;

  assign w_grant_px   = i_px_valid & (r_state == IDLE | r_last_fill);
  assign w_grant_fill = (r_state == FILL) & ~w_grant_px;
  assign w_cmd_acc    = i_cmd_valid & (r_state == IDLE);
  // widened compares so clamping and range checks never wrap
  assign w_h1c   = ({1'b0, i_cmd_h1} > H_LAST) ? H_LAST[HW-1:0] : i_cmd_h1;
  assign w_v1c   = ({1'b0, i_cmd_v1} > V_LAST) ? V_LAST[VW-1:0] : i_cmd_v1;
  assign w_degen = ({1'b0, i_cmd_h0} > {1'b0, w_h1c}) | ({1'b0, i_cmd_v0} > {1'b0, w_v1c}) |
                   ({1'b0, i_cmd_h0} >= H_LIM) | ({1'b0, i_cmd_v0} >= V_LIM);
  assign w_px_in = ({1'b0, i_px_h} < H_LIM) & ({1'b0, i_px_v} < V_LIM);
  assign w_last  = (r_h == r_h1) & (r_v == r_v1);

  assign o_px_ready  = w_grant_px;
  assign o_cmd_ready = r_state == IDLE;
  assign o_busy      = r_state == FILL;
  assign o_done      = r_done;
  assign o_write_en  = r_we;
  assign o_h_pixel   = r_hp;
  assign o_v_pixel   = r_vp;
  assign o_R_out     = r_ro;
  assign o_G_out     = r_go;
  assign o_B_out     = r_bo;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_last_fill <= 1'b1;
      r_h         <= '0;
      r_h0        <= '0;
      r_h1        <= '0;
      r_v         <= '0;
      r_v1        <= '0;
      r_cr        <= '0;
      r_cg        <= '0;
      r_cb        <= '0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_hp        <= '0;
      r_vp        <= '0;
      r_ro        <= '0;
      r_go        <= '0;
      r_bo        <= '0;
    end else begin
      r_done <= (w_cmd_acc & w_degen) | (w_grant_fill & w_last);
      r_we   <= (w_grant_px & w_px_in) | w_grant_fill;
      if (w_grant_px & w_px_in) begin
        r_hp <= i_px_h;
        r_vp <= i_px_v;
        r_ro <= i_px_R;
        r_go <= i_px_G;
        r_bo <= i_px_B;
      end else if (w_grant_fill) begin
        r_hp <= r_h;
        r_vp <= r_v;
        r_ro <= r_cr;
        r_go <= r_cg;
        r_bo <= r_cb;
      end
      if (w_grant_px) r_last_fill <= 1'b0;
      else if (w_grant_fill) r_last_fill <= 1'b1;
      if (w_cmd_acc & ~w_degen) begin
        r_state <= FILL;
        r_h     <= i_cmd_h0;
        r_h0    <= i_cmd_h0;
        r_h1    <= w_h1c;
        r_v     <= i_cmd_v0;
        r_v1    <= w_v1c;
        r_cr    <= i_cmd_R;
        r_cg    <= i_cmd_G;
        r_cb    <= i_cmd_B;
      end else if (w_grant_fill) begin
        if (r_h == r_h1) begin
          r_h <= r_h0;
          if (r_v == r_v1) r_state <= IDLE;
          else r_v <= r_v + 1'b1;
        end else r_h <= r_h + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reflet_vga_pixel_arbiter.sv
// tb_reflet_vga_pixel_arbiter: directed checks of fills, clamping, arbitration and async reset.
module tb_reflet_vga_pixel_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       px_valid = 1'b0, px_ready;
  logic [9:0] px_h = '0;
  logic [8:0] px_v = '0;
  logic [7:0] px_r = '0, px_g = '0, px_b = '0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [9:0] h0 = '0, h1 = '0;
  logic [8:0] v0 = '0, v1 = '0;
  logic [7:0] c_r = '0, c_g = '0, c_b = '0;
  logic       busy, done, we;
  logic [9:0] hp;
  logic [8:0] vp;
  logic [7:0] ro, go, bo;
  int checks = 0, failures = 0;

  reflet_vga_pixel_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_px_valid(px_valid), .o_px_ready(px_ready), .i_px_h(px_h), .i_px_v(px_v),
    .i_px_R(px_r), .i_px_G(px_g), .i_px_B(px_b),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_h0(h0), .i_cmd_v0(v0), .i_cmd_h1(h1), .i_cmd_v1(v1),
    .i_cmd_R(c_r), .i_cmd_G(c_g), .i_cmd_B(c_b),
    .o_busy(busy), .o_done(done), .o_write_en(we), .o_h_pixel(hp), .o_v_pixel(vp),
    .o_R_out(ro), .o_G_out(go), .o_B_out(bo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int h, input int v);
    chk(tag, {44'd0, we, hp, vp}, {44'd0, 1'b1, 10'(h), 9'(v)});
  endtask

  task automatic send_cmd(input int a, input int b, input int c, input int d);
    h0 = 10'(a); v0 = 9'(b); h1 = 10'(c); v1 = 9'(d);
    cmd_valid = 1'b1;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_outs", {we, done, busy, hp, vp, ro, go, bo}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    tick();
    rst = 1'b1;
    tick();

    // uncontended 3x2 fill
    c_r = 8'hFF; c_g = 8'h00; c_b = 8'h00;
    send_cmd(10, 20, 12, 21);
    chk("f1_busy0", {cmd_ready, busy, we}, 3'b010);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_wr("f1_wr", 10 + i % 3, 20 + i / 3);
      chk("f1_done", done, (i == 5) ? 1 : 0);
      chk("f1_busy", busy, (i < 5) ? 1 : 0);
    end
    chk("f1_color", {ro, go, bo}, 24'hFF0000);
    tick();
    chk("f1_after", {we, done, cmd_ready}, 3'b001);

    // clamped fill
    send_cmd(638, 479, 1000, 511);
    tick();
    chk_wr("clamp_wr0", 638, 479);
    chk("clamp_done0", done, 0);
    tick();
    chk_wr("clamp_wr1", 639, 479);
    chk("clamp_done1", done, 1);
    tick();
    chk("clamp_after", {we, done, busy}, 0);

    // degenerate fill
    send_cmd(5, 5, 4, 9);
    chk("degen_pulse", {we, done, busy, cmd_ready}, 4'b0101);
    tick();
    chk("degen_after", {we, done, busy}, 0);

    // out-of-range direct write
    px_h = 10'd640; px_v = 9'd0; px_valid = 1'b1;
    #1 chk("oor_ready", px_ready, 1);
    tick();
    px_valid = 1'b0;
    chk("oor_we", we, 0);

    // in-range direct write
    px_h = 10'd7; px_v = 9'd8; px_r = 8'h12; px_g = 8'h34; px_b = 8'h56; px_valid = 1'b1;
    #1 chk("px_ready", px_ready, 1);
    tick();
    px_valid = 1'b0;
    chk_wr("px_wr", 7, 8);
    chk("px_color", {ro, go, bo}, 24'h123456);

    // contention: last grant was direct, so the fill goes first
    c_r = 8'h0A; c_g = 8'h0B; c_b = 8'h0C;
    px_h = 10'd1; px_v = 9'd1;
    send_cmd(0, 0, 3, 0);
    px_valid = 1'b1;
    #1 chk("cont_ready0", px_ready, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) chk_wr("cont_fill", i / 2, 0);
      else chk_wr("cont_px", 1, 1);
      chk("cont_done", done, (i == 6) ? 1 : 0);
    end
    px_valid = 1'b0;
    tick();
    chk("cont_after", {we, busy}, 0);

    // async reset mid-fill
    send_cmd(100, 50, 102, 51);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_wr("rst_fill_wr", 100 + i, 50);
    end
    rst = 1'b0;
    #1 chk("rst_async", {we, done, busy, hp, vp, ro, go, bo}, 0);
    chk("rst_async_ready", cmd_ready, 1);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_post", {we, busy, cmd_ready}, 3'b001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
